sudoku_solver_top: RTL and testbench
====================================

// Module: sudoku_solver_top
// PURPOSE
//  FPGA top level of the 9x9 sudoku solver. Loads a built-in puzzle and solves it by depth-first
//  backtracking, starting automatically after reset. Push-buttons move a display cursor over the
//  81 cells; the 12 LEDs show cursor index, that cell's value and solver status.
// PARAMETERS
//  PUZZLE           324'h<default>  81 x 4-bit cells; cell i = PUZZLE[4*i+:4], i=row*9+col; 0 = empty
//  DEBOUNCE_CYCLES  16              stable cycles a pb level needs before it is accepted (debounce only)
// PORTS
//  clk     in   1   single system clock; all logic on rising edge
//  rst_n   in   1   reset; asynchronous, ACTIVE-HIGH (name kept per codebase convention)
//  pb      in   5   raw push-buttons, active-high, asynchronous to clk
//  led     out  12  {status, cursor_idx[6:0], cell_val[3:0]}
// BEHAVIOUR
//  - Reset (rst_n=1): grid <= PUZZLE, given[i] <= (PUZZLE cell != 0), solver idx si=0, cursor dc=0,
//    state=SCAN, led <= 12'h000. Solving begins on the first clock after reset deasserts.
//  - pb path: 2-flop synchronizer per bit, then rising-edge detect -> one-cycle pulse per press.
//    Held buttons do not repeat.
//  - Pulse actions, priority pb0>pb4>pb3>pb1>pb2 (at most one action per cycle):
//    pb0 restart (same as reset, except dc is kept); pb4 dc=0; pb3 dc=(dc+9)%81;
//    pb1 dc = dc==80 ? 0 : dc+1; pb2 dc = dc==0 ? 80 : dc-1.
//  - FSM states: SCAN, TRY, CHECK, BACKTRACK, DONE, FAIL.
//    SCAN: if si==81 -> DONE; elif given[si] or grid[si]!=0 -> si+1 (1 cell/cycle); else -> TRY.
//    TRY: cand=grid[si]+1 (on re-entry: cand+1). If cand>9: grid[si]=0 -> BACKTRACK; else j=0 -> CHECK.
//    CHECK: 9 cycles, j=0..8. Conflict if cand equals row cell (r,j) with j!=c, or column cell (j,c)
//      with j!=r, or box cell j with box cell != si. Conflict -> TRY at once. After j=8 with no
//      conflict: grid[si]=cand, si+1 -> SCAN.
//    BACKTRACK: si-1 each cycle; skip givens; below 0 -> FAIL; at a non-given cell -> TRY
//      (cand resumes from grid[si]).
//    DONE/FAIL: hold until reset or pb0. Only pb0 leaves DONE/FAIL.
//  - The solver does not check givens against each other. A puzzle whose givens conflict yields FAIL
//    or an inconsistent DONE.
//  - led is registered (1 cycle after grid/dc change): [10:4]=dc; [3:0]=grid[dc];
//    [11]=1 in DONE or FAIL. In FAIL, [3:0]=4'hF. grid is restored to PUZZLE by the final backtrack.
//  - Grid indices stay 0..80; si range 0..81. Candidate arithmetic is 4-bit; 10 is detected as >9.
//  - The default PUZZLE must reach DONE within 100000 cycles of reset release.
// CONFIGURATION
//  SUDOKU_PB_DEBOUNCE_EN defined: after the synchronizer, each pb bit passes a counter debouncer.
//    A level change is accepted only after DEBOUNCE_CYCLES consecutive stable cycles; the edge
//    detector sees the accepted level.
//  Undefined: synchronizer + edge detect only. DEBOUNCE_CYCLES is ignored.
// STRUCTURE
//  - Package sudoku_pkg: N_CELLS=81, CELL_W=4, default puzzle constant, FSM state enum, and functions
//    row_of(i), col_of(i), box_cell(i,j) (j-th cell of the box containing i).
//  - One sub-module pb_conditioner (sync, optional debounce, edge pulse; 5 bits wide).
//  - Solver FSM and grid storage (81x4 regs + 81-bit given mask) stay in this module.
// TESTING
//  - Reset held 15 cycles with pb=0, default PUZZLE -> led=12'h000 during reset; led[11]=1 and
//    FSM=DONE before cycle 100000; every row, column and box of the grid is a permutation of 1..9.
//  - PUZZLE = valid solution with cell 80 zeroed (answer 9), after DONE pulse pb2 once ->
//    led=={1'b1,7'd80,4'd9}.
//  - PUZZLE with cell 0 empty, row 0 givens 1..8, cell (1,0)=9 -> FAIL, led[11]=1, led[3:0]=4'hF.
//  - Cursor wrap: dc=0, pb2 -> dc=80; pb1 -> 0; pb3 x9 -> 0 (mod 81 path 9..72,0);
//    pb4 from 40 -> 0; pb held 50 cycles = one step.
//  - pb0 asserted mid-CHECK -> next cycle grid==PUZZLE, si=0, state SCAN, dc unchanged; rst_n pulsed
//    mid-solve -> led=12'h000 asynchronously, then solve completes.
//  - SUDOKU_PB_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: pb1 glitch of 5 cycles -> dc unchanged;
//    pb1 held 20 cycles -> dc+1.

Source files
------------

// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM states and grid index helpers for the sudoku solver
package sudoku_pkg;

  localparam int N_CELLS = 81;
  localparam int CELL_W  = 4;
  localparam logic [6:0] SI_END    = 7'd81;
  localparam logic [6:0] LAST_CELL = 7'd80;

  // Rows are listed bottom (row 8) to top (row 0); within a row, col 8 is the leftmost nibble.
  localparam logic [N_CELLS*CELL_W-1:0] DEFAULT_PUZZLE = {
    36'h071680543, 36'h506914082, 36'h480735109,
    36'h658029310, 36'h097308624, 36'h304160958,
    36'h760243091, 36'h843091206, 36'h219806430
  };

  typedef enum logic [2:0] {
    SCAN, TRY, CHECK, BACKTRACK, DONE, FAIL
  } state_t;

  function automatic logic [3:0] row_of(input logic [6:0] i);
    return 4'(i / 7'd9);
  endfunction

  function automatic logic [3:0] col_of(input logic [6:0] i);
    return 4'(i % 7'd9);
  endfunction

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 7'(int'(r) * 9 + int'(c));
  endfunction

  function automatic logic [6:0] box_cell(input logic [6:0] i, input logic [3:0] j);
    int br;
    int bc;
    br = (int'(row_of(i)) / 3) * 3 + int'(j) / 3;
    bc = (int'(col_of(i)) / 3) * 3 + int'(j) % 3;
    return 7'(br * 9 + bc);
  endfunction

endpackage

// File: rtl/sudoku_solver_top_pb_conditioner.sv
// rtl/sudoku_solver_top_pb_conditioner.sv - push-button synchronizer, optional debounce, rising-edge pulse
// Debounce stage present only when SUDOKU_PB_DEBOUNCE_EN is defined.
module pb_conditioner #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pb,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= pb;
      sync2   <= sync1;
      level_d <= level;
    end
  end

`ifdef SUDOKU_PB_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // A new level is taken only once it has differed from the accepted one for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sync2[b] == level[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          level[b] <= sync2[b];
          cnt[b]   <= '0;
        end else begin
          cnt[b] <= cnt[b] + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign level = sync2;
`endif

  assign pulse = level & ~level_d;

endmodule

// File: rtl/sudoku_solver_top.sv
// rtl/sudoku_solver_top.sv - 9x9 sudoku backtracking solver with cursor display on 12 LEDs
// Optional push-button debounce selected by SUDOKU_PB_DEBOUNCE_EN.
module sudoku_solver_top
  import sudoku_pkg::*;
#(
  parameter logic [N_CELLS*CELL_W-1:0] PUZZLE          = DEFAULT_PUZZLE,
  parameter int                        DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  pb,
  output logic [11:0] led
);

  state_t state, state_next;
  logic [CELL_W-1:0] grid [N_CELLS];
  logic [N_CELLS-1:0] given;
  logic [6:0] si, si_next, si_dec, dc, dc_next;
  logic [3:0] cand, cand_next, j, j_next;
  logic [3:0] r, c;
  logic [6:0] row_idx, col_idx, box_idx;
  logic wr_en, restart, conflict;
  logic [CELL_W-1:0] wr_val;
  logic [4:0] pulse;

  pb_conditioner #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb (
    .clk(clk), .rst(rst_n), .pb(pb), .pulse(pulse)
  );

  always_comb begin
    state_next = state;
    si_next    = si;
    cand_next  = cand;
    j_next     = j;
    wr_en      = 1'b0;
    wr_val     = cand;
    restart    = pulse[0];
    si_dec     = si - 7'd1;
    r          = row_of(si);
    c          = col_of(si);
    row_idx    = cell_idx(r, j);
    col_idx    = cell_idx(j, c);
    box_idx    = box_cell(si, j);
    // The cell under test is excluded so its stale value never conflicts with itself.
    conflict   = (j != c && grid[row_idx] == cand) ||
                 (j != r && grid[col_idx] == cand) ||
                 (box_idx != si && grid[box_idx] == cand);
    case (state)
      SCAN: begin
        if (si == SI_END) state_next = DONE;
        else if (given[si] || grid[si] != 4'd0) si_next = si + 7'd1;
        else begin
          cand_next  = 4'd1;
          state_next = TRY;
        end
      end
      TRY: begin
        if (cand > 4'd9) begin
          wr_en      = 1'b1;
          wr_val     = 4'd0;
          state_next = BACKTRACK;
        end else begin
          j_next     = 4'd0;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (conflict) begin
          cand_next  = cand + 4'd1;
          state_next = TRY;
        end else if (j == 4'd8) begin
          wr_en      = 1'b1;
          si_next    = si + 7'd1;
          state_next = SCAN;
        end else begin
          j_next = j + 4'd1;
        end
      end
      BACKTRACK: begin
        if (si == 7'd0) state_next = FAIL;
        else begin
          si_next = si_dec;
          if (!given[si_dec]) begin
            cand_next  = grid[si_dec] + 4'd1;
            state_next = TRY;
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_next = SCAN;
      si_next    = 7'd0;
      cand_next  = 4'd0;
      j_next     = 4'd0;
      wr_en      = 1'b0;
    end
  end

  always_comb begin
    dc_next = dc;
    if (pulse[0])      dc_next = dc;
    else if (pulse[4]) dc_next = 7'd0;
    else if (pulse[3]) dc_next = (dc >= 7'd72) ? dc - 7'd72 : dc + 7'd9;
    else if (pulse[1]) dc_next = (dc == LAST_CELL) ? 7'd0 : dc + 7'd1;
    else if (pulse[2]) dc_next = (dc == 7'd0) ? LAST_CELL : dc - 7'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= SCAN;
      si    <= 7'd0;
      cand  <= 4'd0;
      j     <= 4'd0;
      dc    <= 7'd0;
      led   <= 12'h000;
    end else begin
      state <= state_next;
      si    <= si_next;
      cand  <= cand_next;
      j     <= j_next;
      dc    <= dc_next;
      led   <= {(state == DONE || state == FAIL), dc, (state == FAIL) ? 4'hF : grid[dc]};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < N_CELLS; i++) begin
        grid[i]  <= PUZZLE[CELL_W*i +: CELL_W];
        given[i] <= (PUZZLE[CELL_W*i +: CELL_W] != 4'd0);
      end
    end else if (restart) begin
      for (int i = 0; i < N_CELLS; i++) begin
        grid[i]  <= PUZZLE[CELL_W*i +: CELL_W];
        given[i] <= (PUZZLE[CELL_W*i +: CELL_W] != 4'd0);
      end
    end else if (wr_en) begin
      grid[si] <= wr_val;
    end
  end

endmodule

// File: tb/tb_sudoku_solver_top.sv
// tb/tb_sudoku_solver_top.sv - directed bench for the sudoku solver: solve, unsolvable, cursor, restart
module tb_sudoku_solver_top;
  import sudoku_pkg::*;

  localparam logic [323:0] PUZZLE_B = {
    36'h071682543, 36'h536914782, 36'h482735169,
    36'h658429317, 36'h197358624, 36'h324167958,
    36'h765243891, 36'h843591276, 36'h219876435
  };
  localparam logic [323:0] PUZZLE_C = {252'd0, 36'h000000009, 36'h876543210};
`ifdef SUDOKU_PB_DEBOUNCE_EN
  localparam int HOLD   = 20;
  localparam int SETTLE = 25;
`else
  localparam int HOLD   = 1;
  localparam int SETTLE = 5;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_bc;
  logic [4:0] pb_a, pb_b, pb_c;
  logic [11:0] led_a, led_b, led_c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sudoku_solver_top #(.DEBOUNCE_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_a), .pb(pb_a), .led(led_a));
  sudoku_solver_top #(.PUZZLE(PUZZLE_B), .DEBOUNCE_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_bc), .pb(pb_b), .led(led_b));
  sudoku_solver_top #(.PUZZLE(PUZZLE_C), .DEBOUNCE_CYCLES(16)) dut_c (
    .clk(clk), .rst_n(rst_bc), .pb(pb_c), .led(led_c));

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int sel, input int btn, input int hold);
    if (sel == 0) pb_a[btn] = 1'b1;
    else if (sel == 1) pb_b[btn] = 1'b1;
    else pb_c[btn] = 1'b1;
    cycles(hold);
    pb_a = 5'd0;
    pb_b = 5'd0;
    pb_c = 5'd0;
    cycles(SETTLE);
  endtask

  function automatic logic status_of(input int sel);
    return (sel == 0) ? led_a[11] : (sel == 1) ? led_b[11] : led_c[11];
  endfunction

  task automatic wait_status(input int sel, input int budget, output int used);
    used = 0;
    while (used < budget && !status_of(sel)) begin
      @(negedge clk);
      used++;
    end
  endtask

  task automatic wait_check_state(input int budget, output int used);
    used = 0;
    while (used < budget && dut_a.state != CHECK) begin
      @(negedge clk);
      used++;
    end
  endtask

  initial begin
    int used;
    int diffs;
    int v;
    int cells [81];
    logic [323:0] puz;
    logic [8:0] mask_r, mask_c, mask_b;

    rst_a = 1'b1; rst_bc = 1'b1;
    pb_a = 5'd0; pb_b = 5'd0; pb_c = 5'd0;
    cycles(15);
    check_eq("reset_led_a", led_a, 12'h000);
    check_eq("reset_led_b", led_b, 12'h000);
    check_eq("reset_led_c", led_c, 12'h000);
    rst_a = 1'b0; rst_bc = 1'b0;

    wait_status(0, 100000, used);
    check_eq("a_done_in_budget", int'(used < 100000), 1);
    check_eq("a_done_led", led_a[11], 1);
    check_eq("a_done_state", int'(dut_a.state), int'(DONE));

    diffs = 0;
    for (int i = 0; i < 81; i++) begin
      if (led_a[10:4] != 7'(i)) diffs++;
      cells[i] = int'(led_a[3:0]);
      press(0, 1, HOLD);
    end
    check_eq("scan_cursor", diffs, 0);
    check_eq("pb1_wrap_after_80", led_a[10:4], 0);

    for (int k = 0; k < 9; k++) begin
      mask_r = '0; mask_c = '0; mask_b = '0;
      for (int m = 0; m < 9; m++) begin
        v = cells[k*9 + m];
        if (v >= 1 && v <= 9) mask_r[v-1] = 1'b1;
        v = cells[m*9 + k];
        if (v >= 1 && v <= 9) mask_c[v-1] = 1'b1;
        v = cells[(3*(k/3) + m/3)*9 + 3*(k%3) + m%3];
        if (v >= 1 && v <= 9) mask_b[v-1] = 1'b1;
      end
      check_eq($sformatf("row%0d_perm", k), mask_r, 9'h1FF);
      check_eq($sformatf("col%0d_perm", k), mask_c, 9'h1FF);
      check_eq($sformatf("box%0d_perm", k), mask_b, 9'h1FF);
    end
    puz = DEFAULT_PUZZLE;
    diffs = 0;
    for (int i = 0; i < 81; i++)
      if (puz[4*i +: 4] != 4'd0 && cells[i] != int'(puz[4*i +: 4])) diffs++;
    check_eq("givens_kept", diffs, 0);

    press(0, 2, HOLD);
    check_eq("pb2_wrap", led_a[10:4], 80);
    press(0, 1, HOLD);
    check_eq("pb1_wrap", led_a[10:4], 0);
    for (int k = 1; k <= 9; k++) begin
      press(0, 3, HOLD);
      check_eq($sformatf("pb3_step%0d", k), led_a[10:4], (9 * k) % 81);
    end
    repeat (4) press(0, 3, HOLD);
    repeat (4) press(0, 1, HOLD);
    check_eq("cursor_at_40", led_a[10:4], 40);
    press(0, 4, HOLD);
    check_eq("pb4_home", led_a[10:4], 0);
    press(0, 1, 50);
    check_eq("held_one_step", led_a[10:4], 1);
    check_eq("still_done", led_a[11], 1);

    press(0, 0, HOLD);
    check_eq("pb0_leaves_done", led_a[11], 0);
    wait_check_state(5000, used);
    check_eq("reach_check_1", int'(used < 5000), 1);
    pb_a[0] = 1'b1;
    used = 0;
    while (!dut_a.pulse[0] && used < 100) begin
      @(negedge clk);
      used++;
    end
    check_eq("pb0_pulse_seen", int'(used < 100), 1);
    @(negedge clk);
    pb_a[0] = 1'b0;
    check_eq("restart_state", int'(dut_a.state), int'(SCAN));
    check_eq("restart_si", dut_a.si, 0);
    check_eq("restart_dc", dut_a.dc, 1);
    diffs = 0;
    for (int i = 0; i < 81; i++)
      if (dut_a.grid[i] != puz[4*i +: 4]) diffs++;
    check_eq("restart_grid", diffs, 0);
    cycles(SETTLE);

    wait_check_state(5000, used);
    check_eq("reach_check_2", int'(used < 5000), 1);
    #2 rst_a = 1'b1;
    #1 check_eq("async_reset_led", led_a, 12'h000);
    cycles(2);
    rst_a = 1'b0;
    wait_status(0, 100000, used);
    check_eq("resolve_done", led_a[11], 1);
    check_eq("resolve_dc_home", led_a[10:4], 0);

    wait_status(1, 5000, used);
    check_eq("b_done_led", led_b, 12'h805);
    press(1, 2, HOLD);
    check_eq("b_cell80", led_b, 12'hD09);

    wait_status(2, 5000, used);
    check_eq("c_fail_led", led_c, 12'h80F);
    check_eq("c_fail_state", int'(dut_c.state), int'(FAIL));
    puz = PUZZLE_C;
    diffs = 0;
    for (int i = 0; i < 81; i++)
      if (dut_c.grid[i] != puz[4*i +: 4]) diffs++;
    check_eq("c_grid_restored", diffs, 0);

`ifdef SUDOKU_PB_DEBOUNCE_EN
    press(0, 1, 5);
    check_eq("glitch_ignored", led_a[10:4], 0);
    press(0, 1, 20);
    check_eq("debounced_step", led_a[10:4], 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
